// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl: filters a set-2 keyboard byte stream down to key presses,
// keeps the last four make codes and time-multiplexes them onto a shared
// seven-segment decoder with active-low digit enables.
module scan_display_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic       clear,
    output logic [7:0] digit_code,
    output logic [3:0] an,
    output logic       new_key
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       BREAK_PFX    = 8'hF0;
    localparam logic [7:0]       EXT_PFX      = 8'hE0;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       DIGITS       = 3'd4;

    state_t            state_q, state_d;
    logic              held_q, held_d;
    logic [7:0]        last_q, last_d;
    logic [3:0][7:0]   digits_q, digits_d;   // [0] = most recent key
    logic [2:0]        count_q, count_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  refresh_q, refresh_d;
    logic              new_key_q, new_key_d;
    logic              accept;

    // Next-state logic: refresh scan, prefix filter and digit shift register
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        last_d    = last_q;
        digits_d  = digits_q;
        count_d   = count_q;
        sel_d     = sel_q;
        refresh_d = refresh_q;
        new_key_d = 1'b0;
        accept    = 1'b0;

        // The scan keeps running regardless of clear so the display never stalls
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            sel_d     = sel_q + 2'd1;
        end else begin
            refresh_d = refresh_q + CNT_W'(1);
        end

        if (clear) begin
            // Clear wins over a byte arriving in the same cycle; that byte is dropped
            digits_d = '0;
            count_d  = '0;
            held_d   = 1'b0;
            state_d  = IDLE;
        end else if (code_valid) begin
            case (state_q)
                IDLE: begin
                    if (code == BREAK_PFX) begin
                        state_d = BRK;
                    end else if (code == EXT_PFX) begin
                        state_d = EXT;
                    end else if (!(held_q && code == last_q)) begin
                        // Same code while still held is typematic repeat, not a new press
                        accept = 1'b1;
                    end
                end
                EXT: begin
                    if (code == BREAK_PFX) begin
                        state_d = EXT_BRK;
                    end else if (code == EXT_PFX) begin
                        state_d = EXT;
                    end else begin
                        // Extended make codes are swallowed, never displayed
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    // A normal key was released, so its next make is a genuine press
                    held_d  = 1'b0;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    // Release of an extended key says nothing about the held normal key
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (accept) begin
            digits_d  = {digits_q[2:0], code};
            count_d   = (count_q == DIGITS) ? DIGITS : count_q + 3'd1;
            last_d    = code;
            held_d    = 1'b1;
            new_key_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            held_q    <= 1'b0;
            last_q    <= 8'h00;
            digits_q  <= '0;
            count_q   <= '0;
            sel_q     <= '0;
            refresh_q <= '0;
            new_key_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            last_q    <= last_d;
            digits_q  <= digits_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            refresh_q <= refresh_d;
            new_key_q <= new_key_d;
        end
    end

    // Outputs are pure functions of registered state; unfilled digits stay blank
    always_comb begin
        digit_code = digits_q[sel_q];
        if ({1'b0, sel_q} < count_q) begin
            an = ~(4'b0001 << sel_q);
        end else begin
            an = 4'b1111;
        end
        new_key = new_key_q;
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: table-driven scenarios, digit-rotation scans,
// and a randomized byte stream against a queue-based reference model.
module tb_scan_display_ctrl;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       clear = 1'b0;
    logic [7:0] digit_code;
    logic [3:0] an;
    logic       new_key;

    scan_display_ctrl #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .clear      (clear),
        .digit_code (digit_code),
        .an         (an),
        .new_key    (new_key)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: newest key at the front of the queue, prefix flags
    logic [7:0] mq[$];
    bit         m_ext, m_brk, m_held, m_nk;
    logic [7:0] m_last;
    int         m_edges;

    typedef struct {
        bit         cv;
        logic [7:0] code;
        bit         clr;
        bit         nk;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_held  = 1'b0;
        m_last  = 8'h00;
        m_edges = 0;
        m_nk    = 1'b0;
    endfunction

    function automatic void model_edge(input bit cv, input logic [7:0] c, input bit clr);
        m_edges++;
        m_nk = 1'b0;
        if (clr) begin
            mq.delete();
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_held = 1'b0;
        end else if (cv) begin
            if (m_brk) begin
                if (!m_ext) m_held = 1'b0;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end else if (c == 8'hF0) begin
                m_brk = 1'b1;
            end else if (c == 8'hE0) begin
                m_ext = 1'b1;
            end else if (m_ext) begin
                m_ext = 1'b0;
            end else if (!(m_held && c == m_last)) begin
                mq.push_front(c);
                if (mq.size() > 4) void'(mq.pop_back());
                m_last = c;
                m_held = 1'b1;
                m_nk   = 1'b1;
            end
        end
    endfunction

    task automatic compare_model();
        int         sel;
        logic [3:0] ea;
        logic [7:0] ed;
        sel = (m_edges / RD) % 4;
        if (sel < mq.size()) begin
            ea = ~(4'b0001 << sel);
            ed = mq[sel];
        end else begin
            ea = 4'hF;
            ed = 8'h00;
        end
        chk("model_an", an, ea);
        chk("model_digit_code", digit_code, ed);
        chk("model_new_key", new_key, m_nk);
        chk("an_at_most_one_low", ($countones(~an) <= 1) ? 1 : 0, 1);
    endtask

    task automatic step(input bit cv, input logic [7:0] c, input bit clr);
        code_valid = cv;
        code       = c;
        clear      = clr;
        @(posedge clk);
        model_edge(cv, c, clr);
        #1;
        code_valid = 1'b0;
        clear      = 1'b0;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_digit_code", digit_code, 8'h00);
        chk("async_reset_new_key", new_key, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            step(vecs[i].cv, vecs[i].code, vecs[i].clr);
            chk($sformatf("vec%0d_new_key", i), new_key, vecs[i].nk);
        end
    endtask

    // Watch a full rotation and confirm each filled digit dwells RD cycles with the right code
    task automatic scan_check(input string name, input int n,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        int         cnt[4];
        logic [7:0] seen[4];
        logic [7:0] exp[4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int k = 0; k < 4; k++) begin
            cnt[k]  = 0;
            seen[k] = 8'h00;
        end
        repeat (16) begin
            step(1'b0, 8'h00, 1'b0);
            for (int k = 0; k < 4; k++) begin
                if (an == ~(4'b0001 << k)) begin
                    cnt[k]++;
                    seen[k] = digit_code;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                chk($sformatf("%s_dwell%0d", name, k), cnt[k], RD);
                chk($sformatf("%s_digit%0d", name, k), seen[k], exp[k]);
            end else begin
                chk($sformatf("%s_blank%0d", name, k), cnt[k], 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b[8];
        int r;
        logic [7:0] c;
        bit cv, clr;

        // Scenario tables: {code_valid, code, clear, expected new_key after the edge}
        b[0] = vecs.size();
        vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h32, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        b[1] = vecs.size();
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        b[2] = vecs.size();
        vecs.push_back('{1'b1, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h1C, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        b[3] = vecs.size();
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'hE0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h75, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hE0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h75, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h45, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        b[4] = vecs.size();
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h16, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h1E, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h26, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h25, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h2E, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        b[5] = vecs.size();
        vecs.push_back('{1'b1, 8'h1C, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
        b[6] = vecs.size();

        // Held in reset from time zero
        #2;
        chk("reset_an", an, 4'hF);
        chk("reset_digit_code", digit_code, 8'h00);
        chk("reset_new_key", new_key, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Idle after reset: everything blank
        repeat (20) step(1'b0, 8'h00, 1'b0);

        run_vecs(b[0], b[1]);
        scan_check("two_keys", 2, 8'h32, 8'h1C, 8'h00, 8'h00);
        run_vecs(b[1], b[2]);
        scan_check("autorepeat", 1, 8'h1C, 8'h00, 8'h00, 8'h00);
        run_vecs(b[2], b[3]);
        scan_check("rerelease", 2, 8'h1C, 8'h1C, 8'h00, 8'h00);
        run_vecs(b[3], b[4]);
        scan_check("extended", 1, 8'h45, 8'h00, 8'h00, 8'h00);
        run_vecs(b[4], b[5]);
        scan_check("saturate", 4, 8'h2E, 8'h25, 8'h26, 8'h1E);
        run_vecs(b[5], b[6]);
        scan_check("clear", 0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset in the middle of a break sequence: next byte is a fresh make
        step(1'b1, 8'hF0, 1'b0);
        chk("mid_brk_new_key", new_key, 1'b0);
        do_reset();
        step(1'b1, 8'h24, 1'b0);
        chk("after_reset_accept", new_key, 1'b1);
        scan_check("after_reset", 1, 8'h24, 8'h00, 8'h00, 8'h00);

        // Randomized byte stream against the reference model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 7))
                    0: c = 8'hF0;
                    1: c = 8'hE0;
                    2: c = 8'h1C;
                    3: c = 8'h32;
                    4: c = 8'h45;
                    5: c = 8'h1C;
                    default: c = 8'($urandom_range(0, 255));
                endcase
                cv  = ($urandom_range(0, 2) != 0);
                clr = ($urandom_range(0, 39) == 0);
                step(cv, c, clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
- Sequences a 4-digit multiplexed seven-segment display driven by the scan-code segment decoder.
- Filters the keyboard byte stream (set-2 prefixes 0xE0 and 0xF0) so that only key presses are kept.
- Stores the last four accepted make codes and time-multiplexes them onto one shared decoder input with active-low digit enables.
- Sits between the keyboard byte receiver and the decoder/anode pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays selected; legal range ≥2.
- CNT_W, 17: width of the refresh counter; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- code_valid  input  1  one-cycle strobe; code is valid in this cycle.
- code  input  8  received keyboard byte.
- clear  input  1  synchronous clear of the stored digits.
- digit_code  output  8  stored code for the currently selected digit; drives the decoder input.
- an  output  4  digit enables, active-low; an[0] is the rightmost digit, which shows the most recent key.
- new_key  output  1  one-cycle pulse when a make code is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - buf0..buf3=8'h00, count=0, sel=0, refresh counter=0;
  - FSM=IDLE, held=0, last=8'h00;
  - an=4'b1111, digit_code=8'h00, new_key=0.
- Filter FSM; it advances only on a cycle with code_valid=1.
  - IDLE:
    - 0xF0 -> BRK.
    - 0xE0 -> EXT.
    - Any other code X: if held=1 and X==last, discard (auto-repeat suppression). Otherwise accept X, set last=X, set held=1, stay in IDLE.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0xE0 -> stay in EXT.
    - Any other code: discard -> IDLE. Extended keys are never displayed.
  - BRK: any byte is discarded, held is cleared -> IDLE.
  - EXT_BRK: any byte is discarded -> IDLE; held is unchanged.
- Accept action, on the edge ending the accept cycle N:
  - buf3<=buf2, buf2<=buf1, buf1<=buf0, buf0<=X;
  - count<=min(count+1,4), saturating at 4;
  - new_key=1 during cycle N+1 only.
- Latency: a stored digit is visible on digit_code in cycle N+1 whenever sel selects it.
- clear=1, synchronous:
  - sets buffers=00, count=0, held=0, FSM=IDLE, new_key=0;
  - takes priority over code_valid in the same cycle, so that byte is dropped;
  - sel and the refresh counter keep running.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and then wraps.
  - On the wrap cycle, sel<=sel+1 mod 4, so each digit is held for exactly REFRESH_DIV cycles.
- Outputs are registered state only; there is no combinational path from code, code_valid or clear.
  - digit_code = buf[sel].
  - an = ~(4'b0001<<sel) when sel<count; otherwise an=4'b1111 (unfilled digits are blanked).
- At most one digit enable is low in any cycle.
- Back-to-back code_valid strobes on consecutive cycles must each be processed; there is no busy or back-pressure.
- A byte is never partially applied. Reset in mid-sequence, for example after 0xF0, returns the FSM to IDLE, so the next byte is treated as a fresh make code.

Test Plan (REFRESH_DIV=4):
1. Release rst_n. Check an=1111, digit_code=00 and new_key=0 for 20 cycles. Check sel advances every 4 cycles.
2. Send codes 0x1C and 0x32 with a gap between them, no breaks.
   - new_key pulses once per code, one cycle after each strobe.
   - buf0=0x32 and buf1=0x1C.
   - Digit 0 shows 32 with an=1110; digit 1 shows 1C with an=1101; digits 2 and 3 show an=1111.
3. Auto-repeat: send 0x1C, 0x1C, 0x1C.
   - Only one accept occurs and count=1.
   - Then send F0 1C, then 0x1C: the last code is accepted, buf0=1C, buf1=1C, count=2.
4. Extended keys: send E0 75, then E0 F0 75, then 0x45.
   - Only 0x45 is stored and exactly one new_key pulse occurs.
   - The FSM passes IDLE->EXT->IDLE->EXT->EXT_BRK->IDLE.
5. Send five distinct codes 16,1E,26,25,2E on consecutive cycles.
   - count saturates at 4.
   - buf0..3 = 2E,25,26,1E; 16 is lost.
   - Exactly five new_key pulses occur.
   - All four an patterns 1110, 1101, 1011, 0111 appear in rotation.
6. Assert clear together with code_valid carrying code 0x1C.
   - The buffer empties, 0x1C is not stored, new_key stays 0 and an=1111.
   - Then send F0, pulse rst_n low mid-idle, and send 0x24: 0x24 is accepted after reset.
